taillight_sequencer: RTL and testbench

- Clocked controller that arbitrates turn, hazard and brake requests for the tail-light bank.
- Sequences the 3-lamp sweep on each side.
- Sits between the switch/key inputs and LEDR[9:7]/LEDR[2:0]; replaces the per-side blink sequencing with one synchronous FSM.
- Advances on single-cycle tick pulses from the clock divider.

---
 rtl/taillight_sequencer.sv | 66 ++++++
 tb/tb_taillight_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/taillight_sequencer.sv
// taillight_sequencer: arbitrates turn/hazard/brake requests and sweeps the 3-lamp tail-light banks.
module taillight_sequencer #(
    parameter int HOLD_TICKS = 1,
    parameter int TCW        = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake_req,
    output logic [2:0] left_leds,
    output logic [2:0] right_leds,
    output logic [2:0] mode
);
    typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZARD, BRAKE_ALL} mode_t;
    localparam logic [TCW-1:0] LAST = TCW'(HOLD_TICKS - 1);
    // request vectors are packed {brake, hazard, right, left}
    logic [3:0]     s1, s2;
    mode_t          mode_q, mode_d;
    logic [1:0]     step_q, step_d;
    logic [TCW-1:0] cnt_q, cnt_d;
    logic [2:0]     pat, l_d, r_d;
    always_comb begin
        mode_d = (s2[3] && (s2[2] || (s2[0] == s2[1]))) ? BRAKE_ALL :
                 (s2[2] || (s2[0] && s2[1]))            ? HAZARD    :
                 s2[0]                                  ? LEFT      :
                 s2[1]                                  ? RIGHT     : IDLE;
        step_d = step_q;
        cnt_d  = cnt_q;
        if (mode_d != mode_q || mode_q == IDLE || mode_q == BRAKE_ALL) begin
            step_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            step_d = (cnt_q == LAST) ? step_q + 2'd1 : step_q;
        end
        pat = {step_q == 2'd3, step_q[1], step_q != 2'd0};
        // brake during a turn lights the opposite (non-turning) side solid
        l_d = (mode_q == LEFT || mode_q == HAZARD) ? pat :
              (mode_q == BRAKE_ALL || (mode_q == RIGHT && s2[3])) ? 3'b111 : 3'b000;
        r_d = (mode_q == RIGHT || mode_q == HAZARD) ? pat :
              (mode_q == BRAKE_ALL || (mode_q == LEFT && s2[3])) ? 3'b111 : 3'b000;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1         <= '0;
            s2         <= '0;
            mode_q     <= IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            left_leds  <= '0;
            right_leds <= '0;
        end else begin
            s1         <= {brake_req, hazard_req, right_req, left_req};
            s2         <= s1;
            mode_q     <= mode_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            left_leds  <= l_d;
            right_leds <= r_d;
        end
    end
    assign mode = mode_q;
endmodule

// File: tb/tb_taillight_sequencer.sv
// tb_taillight_sequencer: vector table, hand-written corner sequences and a randomized run against a behavioural model.
module tb_taillight_sequencer;
    localparam int HOLD = 2;
    logic       clock = 0, reset_n = 0, tick = 0;
    logic       left_req = 0, right_req = 0, hazard_req = 0, brake_req = 0;
    logic [2:0] left_leds, right_leds, mode;
    int         checks = 0, errors = 0;

    taillight_sequencer #(.HOLD_TICKS(HOLD), .TCW(8)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .left_req(left_req), .right_req(right_req),
        .hazard_req(hazard_req), .brake_req(brake_req),
        .left_leds(left_leds), .right_leds(right_leds), .mode(mode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: step derived from the number of counted ticks since mode entry.
    function automatic logic [2:0] arb_of(input logic [3:0] p);
        logic b, h, r, l;
        {b, h, r, l} = p;
        if (b && (h || (l && r) || (!l && !r))) return 3'd4;
        if (h || (l && r)) return 3'd3;
        if (l) return 3'd1;
        if (r) return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [2:0] pat_of(input int t);
        int st;
        st = (t / HOLD) % 4;
        return 3'((1 << st) - 1);
    endfunction

    logic [3:0] p1, p2;
    logic [2:0] m_mode, m_l, m_r;
    int         m_ticks;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1 <= '0; p2 <= '0; m_mode <= '0; m_ticks <= 0; m_l <= '0; m_r <= '0;
        end else begin
            m_l <= (m_mode == 3'd1 || m_mode == 3'd3) ? pat_of(m_ticks) :
                   (m_mode == 3'd4 || (m_mode == 3'd2 && p2[3])) ? 3'b111 : 3'b000;
            m_r <= (m_mode == 3'd2 || m_mode == 3'd3) ? pat_of(m_ticks) :
                   (m_mode == 3'd4 || (m_mode == 3'd1 && p2[3])) ? 3'b111 : 3'b000;
            m_mode  <= arb_of(p2);
            m_ticks <= (arb_of(p2) != m_mode) ? 0 :
                       ((m_mode inside {3'd1, 3'd2, 3'd3}) && tick) ? m_ticks + 1 : m_ticks;
            p2 <= p1;
            p1 <= {brake_req, hazard_req, right_req, left_req};
        end
    end

    typedef struct {
        logic [3:0] req;
        logic       tk;
        logic [2:0] l, r, m;
    } vec_t;
    vec_t vecs[15];

    initial begin
        bit found;
        vecs[0]  = '{4'b0001, 1'b0, 3'b000, 3'b000, 3'd0};
        vecs[1]  = '{4'b0001, 1'b0, 3'b000, 3'b000, 3'd0};
        vecs[2]  = '{4'b0001, 1'b0, 3'b000, 3'b000, 3'd1};
        vecs[3]  = '{4'b0001, 1'b1, 3'b000, 3'b000, 3'd1};
        vecs[4]  = '{4'b0001, 1'b1, 3'b000, 3'b000, 3'd1};
        vecs[5]  = '{4'b0001, 1'b1, 3'b001, 3'b000, 3'd1};
        vecs[6]  = '{4'b0001, 1'b1, 3'b001, 3'b000, 3'd1};
        vecs[7]  = '{4'b0001, 1'b1, 3'b011, 3'b000, 3'd1};
        vecs[8]  = '{4'b0001, 1'b1, 3'b011, 3'b000, 3'd1};
        vecs[9]  = '{4'b0001, 1'b1, 3'b111, 3'b000, 3'd1};
        vecs[10] = '{4'b0001, 1'b1, 3'b111, 3'b000, 3'd1};
        vecs[11] = '{4'b0001, 1'b0, 3'b000, 3'b000, 3'd1};
        vecs[12] = '{4'b1001, 1'b0, 3'b000, 3'b000, 3'd1};
        vecs[13] = '{4'b1001, 1'b0, 3'b000, 3'b000, 3'd1};
        vecs[14] = '{4'b1001, 1'b0, 3'b000, 3'b111, 3'd1};

        repeat (3) @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick = (i % 4 == 0);
            @(negedge clock);
            chk("idle_left", left_leds, 3'b000);
            chk("idle_right", right_leds, 3'b000);
            chk("idle_mode", mode, 3'd0);
        end
        for (int i = 0; i < 15; i++) begin
            {brake_req, hazard_req, right_req, left_req} = vecs[i].req;
            tick = vecs[i].tk;
            @(negedge clock);
            chk($sformatf("vec%0d_left", i), left_leds, vecs[i].l);
            chk($sformatf("vec%0d_right", i), right_leds, vecs[i].r);
            chk($sformatf("vec%0d_mode", i), mode, vecs[i].m);
        end

        brake_req = 0;
        tick = 1;
        repeat (3) @(negedge clock);
        chk("pre_reset_left", left_leds, 3'b001);
        #2 reset_n = 0;
        #1;
        chk("async_reset_left", left_leds, 3'b000);
        chk("async_reset_right", right_leds, 3'b000);
        chk("async_reset_mode", mode, 3'd0);
        {tick, left_req, right_req, hazard_req, brake_req} = '0;
        repeat (2) @(negedge clock);
        reset_n = 1;

        left_req = 1;
        tick = 1;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            found = (left_leds == 3'b111);
        end
        chk("left_reaches_111", left_leds, 3'b111);
        tick = 0;
        left_req = 0;
        right_req = 1;
        @(negedge clock);
        @(negedge clock);
        chk("switch_e2_mode", mode, 3'd1);
        chk("switch_e2_left", left_leds, 3'b111);
        tick = 1;
        @(negedge clock);
        chk("switch_e3_mode", mode, 3'd2);
        chk("switch_e3_left", left_leds, 3'b111);
        @(negedge clock);
        chk("switch_e4_left", left_leds, 3'b000);
        chk("switch_e4_right", right_leds, 3'b000);
        @(negedge clock);
        chk("coincident_tick_ignored", right_leds, 3'b000);
        tick = 0;
        @(negedge clock);
        chk("switch_right_step1", right_leds, 3'b001);

        reset_n = 0;
        {tick, left_req, right_req, hazard_req, brake_req} = '0;
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) left_req = ~left_req;
            if ($urandom_range(0, 15) == 0) right_req = ~right_req;
            if ($urandom_range(0, 23) == 0) hazard_req = ~hazard_req;
            if ($urandom_range(0, 19) == 0) brake_req = ~brake_req;
            tick = ($urandom_range(0, 2) == 0);
            @(negedge clock);
            chk("rand_left", left_leds, m_l);
            chk("rand_right", right_leds, m_r);
            chk("rand_mode", mode, m_mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
